// File: rtl/seq_mult_32b_pkg.sv
// Shared constants and state encoding for the shift-add sequential multiplier.
package seq_mult_32b_pkg;

    localparam int WIDTH     = 32;
    localparam int LAST_ITER = 31;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/and_32b.sv
// 32-bit bitwise AND block shared with the ALU datapath.
module and_32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a & b;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencer for seq_mult_32b: FSM plus iteration counter, emitting load/shift strobes.
module seq_mult_ctrl #(
    parameter int CNT_W     = 6,
    parameter int LAST_ITER = seq_mult_32b_pkg::LAST_ITER
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load,
    output logic shift_en
);

    import seq_mult_32b_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (load)
                count <= '0;
            else if (shift_en)
                count <= count + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (count == CNT_W'(LAST_ITER))
                    state_next = DONE;
            end
            DONE: begin
                // A start in the done cycle chains straight into the next operation.
                done       = 1'b1;
                state_next = IDLE;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/seq_mult_32b.sv
// Unsigned shift-add sequential multiplier: one multiplier bit per cycle, 64-bit product.
module seq_mult_32b #(
    parameter int WIDTH = seq_mult_32b_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import seq_mult_32b_pkg::*;

    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   sum;

    seq_mult_ctrl #(
        .CNT_W     (CNT_W),
        .LAST_ITER (WIDTH - 1)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .load     (load),
        .shift_en (shift_en)
    );

    and_32b u_and (
        .a (mcand),
        .b ({WIDTH{product[0]}}),
        .y (pp)
    );

    // Carry out of the high-half add lands in the product MSB on the shift.
    assign sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, pp};

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            product <= '0;
        end else if (load) begin
            mcand   <= a;
            product <= {{WIDTH{1'b0}}, b};
        end else if (shift_en) begin
            product <= {sum, product[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_seq_mult_32b.sv
// Scoreboard bench for seq_mult_32b: directed corner cases plus randomized operations.
module tb_seq_mult_32b;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc;
    int          busy_until;
    int          checks;
    int          errors;
    logic [63:0] last_prod;
    bit          hold_valid;

    seq_mult_32b #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        checks++;
        if (busy === 1'b1 && done === 1'b1) begin
            errors++;
            $display("FAIL busy_done_overlap: busy=%b done=%b expected not both high", busy, done);
        end
        if (reset) begin
            hold_valid = 1'b0;
        end else if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with product %h expected no done", product);
            end else begin
                exp_t e;
                e = q.pop_front();
                check64("product", product, e.prod);
                check64("done_latency", 64'(cyc), 64'(e.due));
                last_prod  = product;
                hold_valid = 1'b1;
            end
        end else if (busy === 1'b0 && hold_valid) begin
            check64("product_hold", product, last_prod);
        end else if (busy === 1'b1) begin
            hold_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input bit hold);
        exp_t e;
        while (cyc < busy_until) tick();
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        e.prod     = 64'(ia) * 64'(ib);
        e.due      = cyc + 32;
        busy_until = cyc + 32;
        q.push_back(e);
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
        tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        q.delete();
        busy_until = 0;
        check64("reset_busy", 64'(busy), 64'd0);
        check64("reset_done", 64'(done), 64'd0);
        check64("reset_product", product, 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        hold_valid = 1'b0;
        busy_until = 0;
        reset      = 1'b1;
        start      = 1'b0;
        a          = '0;
        b          = '0;
        tick();
        do_reset(2);

        issue(32'd3, 32'd5, 1'b0);
        drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drain();
        issue(32'd0, 32'h1234_5678, 1'b0);
        drain();
        issue(32'h1234_5678, 32'd1, 1'b0);
        drain();

        // Start while busy must be ignored, with operands scrambled afterwards.
        issue(32'd7, 32'd6, 1'b0);
        repeat (9) tick();
        a     = 32'd9;
        b     = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        drain();

        issue(32'd100, 32'd200, 1'b0);
        repeat (14) tick();
        do_reset(1);
        repeat (3) tick();
        issue(32'd100, 32'd200, 1'b0);
        drain();

        // Back-to-back: start held through the run, second operands present in the done cycle.
        issue(32'd2, 32'd3, 1'b1);
        a = 32'd4;
        b = 32'd5;
        issue(32'd4, 32'd5, 1'b0);
        drain();

        for (int n = 0; n < 24; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (n % 6 == 0) ra = 32'hFFFF_FFFF;
            if (n % 7 == 0) rb = 32'h8000_0001;
            issue(ra, rb, 1'b0);
            for (int k = 0; k < int'($urandom_range(0, 40)); k++) begin
                a = $urandom;
                b = $urandom;
                tick();
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
